// File: rtl/mac_chk_pkg.sv
// Shared types and widths for the MAC result checker.
package mac_chk_pkg;

  localparam int OP_W  = 14;
  localparam int ACC_W = 28;

  typedef logic signed [OP_W-1:0]  op_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FAIL = 2'd2
  } chk_state_e;

endpackage

// File: rtl/mac_chk_fifo.sv
// Expected-value queue for the MAC result checker; a push into a full queue
// is accepted only when a pop frees a slot in the same cycle.
module mac_chk_fifo
  import mac_chk_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  acc_t din,
  output logic full,
  output logic empty,
  output logic last,
  output acc_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  acc_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign last    = (count == ONE_CNT);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_result_checker.sv
// On-line checker for the pipelined MAC: golden accumulator, expected queue,
// compare and status. Define MAC_CHK_TIMEOUT_EN to build the result watchdog.
//
// state | meaning
// IDLE  | no expected results outstanding
// BUSY  | at least one expected result queued
// FAIL  | an error was seen since reset; checking continues
module mac_result_checker
  import mac_chk_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic signed [OP_W-1:0]  a,
  input  logic signed [OP_W-1:0]  b,
  input  logic                    valid_out,
  input  logic signed [ACC_W-1:0] f,
  output logic                    chk_valid,
  output logic                    chk_pass,
  output logic signed [ACC_W-1:0] exp_f,
  output logic                    err,
  output logic [CNT_W-1:0]        pass_cnt,
  output logic [CNT_W-1:0]        fail_cnt,
  output logic                    underflow,
  output logic                    overflow,
  output logic                    timeout
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("mac_result_checker: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  chk_state_e state, state_next;
  acc_t       acc, acc_next, head;
  logic       fifo_full, fifo_empty, fifo_last;
  logic       cmp_ev, pass_ev, mismatch_ev, underflow_ev, overflow_ev, timeout_ev, error_ev;

  // Full-width signed product; the running sum wraps modulo 2^ACC_W.
  assign acc_next = acc + acc_t'(a) * acc_t'(b);

  mac_chk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (valid_in),
    .pop   (valid_out),
    .din   (acc_next),
    .full  (fifo_full),
    .empty (fifo_empty),
    .last  (fifo_last),
    .head  (head)
  );

  assign cmp_ev       = valid_out && !fifo_empty;
  assign pass_ev      = cmp_ev && (f == head);
  assign mismatch_ev  = cmp_ev && (f != head);
  assign underflow_ev = valid_out && fifo_empty;
  assign overflow_ev  = valid_in && fifo_full && !valid_out;
  assign error_ev     = mismatch_ev || underflow_ev || overflow_ev || timeout_ev;

`ifdef MAC_CHK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] wd_cnt;

  // Reloads whenever nothing is outstanding or a result arrives.
  always_ff @(posedge clk) begin
    if (reset || fifo_empty || valid_out) wd_cnt <= WD_LOAD;
    else if (wd_cnt != '0)                wd_cnt <= wd_cnt - 1'b1;
  end

  assign timeout_ev = !fifo_empty && !valid_out && (wd_cnt == WD_ONE);
`else
  assign timeout_ev = 1'b0;
`endif

  always_comb begin
    state_next = state;
    if (error_ev) begin
      state_next = FAIL;
    end else begin
      case (state)
        IDLE:    if (valid_in && !valid_out) state_next = BUSY;
        BUSY:    if (valid_out && !valid_in && fifo_last) state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      exp_f     <= '0;
      err       <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_next;
      chk_valid <= cmp_ev;
      chk_pass  <= pass_ev;
      if (valid_in) acc   <= acc_next;
      if (cmp_ev)   exp_f <= head;
      if (pass_ev && pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      if ((mismatch_ev || underflow_ev) && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      err       <= err || error_ev;
      underflow <= underflow || underflow_ev;
      overflow  <= overflow || overflow_ev;
      timeout   <= timeout || timeout_ev;
    end
  end

endmodule

// File: tb/tb_mac_result_checker.sv
// Self-checking bench for mac_result_checker: directed scenarios plus a random
// stream, all scored against a queue-based reference of the golden sum.
module tb_mac_result_checker;
  import mac_chk_pkg::*;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid_in = 1'b0;
  logic valid_out = 1'b0;
  logic signed [13:0] a = '0;
  logic signed [13:0] b = '0;
  logic signed [27:0] f = '0;
  logic chk_valid, chk_pass, err, underflow, overflow, timeout;
  logic [27:0] exp_f;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;

  int checks = 0;
  int failures = 0;

  // reference model state
  longint      sum;
  logic [27:0] exp_q[$];
  int          m_pass, m_fail, idle_run;
  bit          m_err, m_uf, m_of, m_to;

  mac_result_checker #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .a(a), .b(b),
    .valid_out(valid_out), .f(f), .chk_valid(chk_valid), .chk_pass(chk_pass),
    .exp_f(exp_f), .err(err), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .underflow(underflow), .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status();
    chk_eq("pass_cnt", pass_cnt, m_pass);
    chk_eq("fail_cnt", fail_cnt, m_fail);
    chk_eq("err", err, m_err);
    chk_eq("underflow", underflow, m_uf);
    chk_eq("overflow", overflow, m_of);
    chk_eq("timeout", timeout, m_to);
    chk_eq("state", dut.state, m_err ? FAIL : (exp_q.size() > 0 ? BUSY : IDLE));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid_in = 1'b0;
    valid_out = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    sum = 0; m_pass = 0; m_fail = 0; idle_run = 0;
    m_err = 0; m_uf = 0; m_of = 0; m_to = 0;
    chk_eq("rst_chk_valid", chk_valid, 1'b0);
    chk_eq("rst_chk_pass", chk_pass, 1'b0);
    chk_eq("rst_exp_f", exp_f, 28'd0);
    check_status();
  endtask

  // One clock of stimulus; the MAC is played by the bench, returning the
  // queued expectation as f (optionally corrupted).
  task automatic cycle(input bit vi, input int av, input int bv, input bit vo, input bit corrupt);
    logic [27:0] e;
    bit cmp;
    bit pass_e;
    int pre;
    e = '0; cmp = 0; pass_e = 0;
    pre = exp_q.size();
    valid_in = vi;
    a = 14'(av);
    b = 14'(bv);
    valid_out = vo;
    f = 28'($urandom);
    if (vo && pre > 0) begin
      e = exp_q.pop_front();
      cmp = 1;
      pass_e = !corrupt;
      f = corrupt ? e + 28'd1 : e;
      if (pass_e) m_pass++;
      else begin m_fail++; m_err = 1; end
    end
    if (vo && pre == 0) begin m_uf = 1; m_err = 1; m_fail++; end
    if (vi) begin
      sum += longint'(av) * longint'(bv);
      if (pre < DEPTH || (vo && pre > 0)) exp_q.push_back(sum[27:0]);
      else begin m_of = 1; m_err = 1; end
    end
    if (pre > 0 && !vo) idle_run++;
    else idle_run = 0;
`ifdef MAC_CHK_TIMEOUT_EN
    if (idle_run == TIMEOUT) begin m_to = 1; m_err = 1; end
`endif
    @(posedge clk); #1;
    valid_in = 1'b0;
    valid_out = 1'b0;
    chk_eq("chk_valid", chk_valid, cmp);
    if (cmp) begin
      chk_eq("exp_f", exp_f, e);
      chk_eq("chk_pass", chk_pass, pass_e);
    end
    check_status();
  endtask

  initial begin
    int gap;
    bit vi, vo;

    // basic single result
    do_reset();
    cycle(1, 3, 4, 0, 0);
    cycle(0, 0, 0, 1, 0);
    chk_eq("t1_exp_f", exp_f, 28'd12);
    chk_eq("t1_pass", chk_pass, 1'b1);
    chk_eq("t1_pass_cnt", pass_cnt, 16'd1);

    // injected mismatch on second result
    do_reset();
    cycle(1, -2, 5, 0, 0);
    cycle(1, 7, 7, 1, 0);
    chk_eq("t2_first", exp_f, 28'hFFFFFF6);
    cycle(0, 0, 0, 1, 1);
    chk_eq("t2_exp_f", exp_f, 28'd39);
    chk_eq("t2_fail_cnt", fail_cnt, 16'd1);
    chk_eq("t2_state", dut.state, FAIL);

    // accumulator wrap modulo 2^28
    do_reset();
    cycle(1, -8192, -8192, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      cycle(1, -8192, -8192, 1, 0);
      if (i == 16) chk_eq("t3_16th", exp_f, 28'd0);
    end
    cycle(0, 0, 0, 1, 0);
    chk_eq("t3_17th", exp_f, 28'h4000000);
    chk_eq("t3_pass_cnt", pass_cnt, 16'd17);

    // underflow
    do_reset();
    cycle(0, 0, 0, 1, 0);
    chk_eq("t4_underflow", underflow, 1'b1);
    chk_eq("t4_fail_cnt", fail_cnt, 16'd1);

    // overflow, then watchdog
    do_reset();
    for (int i = 0; i < 9; i++)
      cycle(1, $urandom_range(0, 16383) - 8192, $urandom_range(0, 16383) - 8192, 0, 0);
    chk_eq("t5_overflow", overflow, 1'b1);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0);
`ifdef MAC_CHK_TIMEOUT_EN
    chk_eq("t5_timeout", timeout, 1'b1);
`else
    chk_eq("t5_timeout", timeout, 1'b0);
`endif

    // reset mid-stream with entries queued and errors latched
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, i + 2, -i, 0, 0);
    cycle(0, 0, 0, 1, 1);
    chk_eq("t6_pre_err", err, 1'b1);
    do_reset();
    cycle(1, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, 0);
    chk_eq("t6_exp_f", exp_f, 28'd1);
    chk_eq("t6_pass", chk_pass, 1'b1);

    // random stream with back-to-back traffic
    do_reset();
    gap = 0;
    for (int i = 0; i < 400; i++) begin
      vo = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0 || gap >= 6);
      vi = (exp_q.size() < DEPTH || vo) && ($urandom_range(0, 3) != 0);
      gap = vo ? 0 : gap + 1;
      cycle(vi, $urandom_range(0, 16383) - 8192, $urandom_range(0, 16383) - 8192, vo, 0);
    end
    while (exp_q.size() > 0) cycle(0, 0, 0, 1, 0);
    chk_eq("t7_no_err", err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL tb_time_limit got=expired exp=finished");
    $fatal(1);
  end

endmodule
